hazard_scoreboard: RTL

Parametrised scoreboard hazard unit for the mycpu pipeline, generalising fixed-stage compare logic to any number of in-flight writers with variable result latency (loads, mult/div). It tracks one pending entry per architectural register and stalls issue while any source operand's producer is not yet forwardable. It tells the datapath which tagged result bus to bypass from, and clears entries on tagged writeback or on an exception flush.

---
 rtl/hazard_scoreboard.sv | 118 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register scoreboard hazard/forwarding unit with tagged writers
module hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int RIDX_W = 5,
  parameter int NSRC   = 2,
  parameter int LAT_W  = 3,
  parameter int TAG_W  = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   issue_valid,
  input  logic                   issue_wen,
  input  logic [RIDX_W-1:0]      issue_dst,
  input  logic [LAT_W-1:0]       issue_lat,
  input  logic [NSRC*RIDX_W-1:0] issue_src,
  output logic                   issue_stall,
  output logic [TAG_W-1:0]       issue_tag,
  output logic [NSRC-1:0]        fwd_valid,
  output logic [NSRC*TAG_W-1:0]  fwd_tag,
  input  logic                   freeze,
  input  logic                   flush,
  input  logic                   wb_valid,
  input  logic [RIDX_W-1:0]      wb_dst,
  input  logic [TAG_W-1:0]       wb_tag,
  output logic [RIDX_W:0]        busy_cnt
);

  logic [NREG-1:0]   r_pending;
  logic [LAT_W-1:0]  r_cnt [NREG];
  logic [TAG_W-1:0]  r_tag [NREG];
  logic [TAG_W-1:0]  r_next_tag;
  logic [RIDX_W:0]   r_busy_cnt;

  logic [NREG-1:0]   w_pending;
  logic [LAT_W-1:0]  w_cnt [NREG];
  logic [TAG_W-1:0]  w_tag [NREG];
  logic [RIDX_W:0]   w_busy;
  logic [RIDX_W-1:0] w_src  [NSRC];
  logic [NSRC-1:0]   w_live;
  logic [NSRC-1:0]   w_haz;
  logic              w_accept;
  logic              w_alloc;

  // Per-source lookup: a pending producer is a hazard until its countdown reaches zero,
  // after which the operand is taken from the forward bus carrying the producer's tag.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign w_src[gi]                   = issue_src[gi*RIDX_W +: RIDX_W];
    assign w_live[gi]                  = (w_src[gi] != '0) & r_pending[w_src[gi]];
    assign w_haz[gi]                   = w_live[gi] & (r_cnt[w_src[gi]] != '0);
    assign fwd_valid[gi]               = w_live[gi] & (r_cnt[w_src[gi]] == '0);
    assign fwd_tag[gi*TAG_W +: TAG_W]  = r_tag[w_src[gi]];
  end

  assign issue_stall = issue_valid & ((|w_haz) | freeze);
  assign w_accept    = issue_valid & ~issue_stall & ~flush;
  assign w_alloc     = w_accept & issue_wen & (issue_dst != '0);
  assign issue_tag   = r_next_tag;
  assign busy_cnt    = r_busy_cnt;

  // Next entry state: countdown, then tagged writeback, then issue (issue wins), flush overrides all.
  always_comb begin
    w_pending = r_pending;
    w_cnt     = r_cnt;
    w_tag     = r_tag;
    for (int r = 1; r < NREG; r++) begin
      if (!freeze && r_pending[r] && (r_cnt[r] != '0)) begin
        w_cnt[r] = r_cnt[r] - 1'b1;
      end
      if (wb_valid && (wb_dst == RIDX_W'(r)) && r_pending[r] && (r_tag[r] == wb_tag)) begin
        w_pending[r] = 1'b0;
      end
      if (w_alloc && (issue_dst == RIDX_W'(r))) begin
        w_pending[r] = 1'b1;
        w_cnt[r]     = issue_lat;
        w_tag[r]     = r_next_tag;
      end
    end
    if (flush) begin
      w_pending = '0;
      for (int r = 0; r < NREG; r++) begin
        w_cnt[r] = '0;
      end
    end
    w_pending[0] = 1'b0;
  end

  // Population count of the next pending set so busy_cnt tracks the registered entries.
  always_comb begin
    w_busy = '0;
    for (int r = 0; r < NREG; r++) begin
      w_busy = w_busy + (RIDX_W+1)'(w_pending[r]);
    end
  end

  // State registers; tags keep advancing across flushes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending  <= '0;
      r_next_tag <= '0;
      r_busy_cnt <= '0;
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
        r_tag[r] <= '0;
      end
    end else begin
      r_pending  <= w_pending;
      r_busy_cnt <= w_busy;
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= w_cnt[r];
        r_tag[r] <= w_tag[r];
      end
      if (w_accept) begin
        r_next_tag <= r_next_tag + 1'b1;
      end
    end
  end

endmodule
